// File: rtl/gbhr_sched.sv
// Arbitrates the GBHR update port between predict pushes and resolve pops, tracking in-flight
// predicted directions and flagging mispredicts. Optional round-robin arbitration: GBHR_SCHED_RR_EN.
module gbhr_sched #(
  parameter int unsigned W_PHT = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EN,
  input  logic                     pred_req,
  input  logic                     pred_taken,
  output logic                     pred_ack,
  input  logic                     res_req,
  input  logic                     res_taken,
  output logic                     res_ack,
  output logic                     predict,
  output logic                     resolve,
  output logic                     pr_br_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [W_PHT-1:0]         spec_hist
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  fifo_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              predict_q, resolve_q, pr_br_taken_q, mispredict_q;
  logic [W_PHT-1:0]  spec_hist_q;

  logic empty, full, grant_ok, res_elig, pred_elig, head, miss;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign grant_ok  = EN && (state_q == StRun);
  assign res_elig  = res_req && !empty;
  assign pred_elig = pred_req && !full;
  assign head      = fifo_q[rd_ptr_q];
  assign miss      = res_ack && (res_taken != head);

`ifdef GBHR_SCHED_RR_EN
  logic last_grant_q;  // 1: resolve won the most recent contested cycle
  logic contested;
  assign contested = res_elig && pred_elig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else if (grant_ok && contested) begin
      last_grant_q <= res_ack;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FLUSH only advances on an enabled cycle
  always_comb begin
    state_d = state_q;
    if (EN) begin
      unique case (state_q)
        StRun:   if (miss) state_d = StFlush;
        StFlush: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // Grant outputs
  always_comb begin
    res_ack  = 1'b0;
    pred_ack = 1'b0;
    if (grant_ok) begin
`ifdef GBHR_SCHED_RR_EN
      res_ack = res_elig && (!contested || !last_grant_q);
`else
      res_ack = res_elig;
`endif
      pred_ack = pred_elig && !res_ack;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      predict_q     <= 1'b0;
      resolve_q     <= 1'b0;
      pr_br_taken_q <= 1'b0;
      mispredict_q  <= 1'b0;
      spec_hist_q   <= '0;
    end else begin
      predict_q    <= pred_ack;
      resolve_q    <= res_ack;
      mispredict_q <= miss;
      if (pred_ack) begin
        fifo_q[wr_ptr_q] <= pred_taken;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
        count_q          <= count_q + CW'(1);
        pr_br_taken_q    <= pred_taken;
        spec_hist_q      <= {spec_hist_q[W_PHT-2:0], pred_taken};
      end else if (res_ack) begin
        pr_br_taken_q <= res_taken;
        spec_hist_q   <= {spec_hist_q[W_PHT-2:0], res_taken};
        if (miss) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
          count_q  <= count_q - CW'(1);
        end
      end
    end
  end

  assign predict     = predict_q;
  assign resolve     = resolve_q;
  assign pr_br_taken = pr_br_taken_q;
  assign mispredict  = mispredict_q;
  assign inflight    = count_q;
  assign spec_hist   = spec_hist_q;

endmodule
